fp_add_pipe: RTL and testbench
==============================

FP_ADD_PIPE -- requirements
Module: fp_add_pipe

Interface
REQ-001 SHALL have parameter EXP_W, default 8, exponent field width.
REQ-002 SHALL have parameter MAN_W, default 23, stored fraction width (word W = 1+EXP_W+MAN_W).
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port in_valid  input  1  operand pair present.
REQ-006 SHALL have port in_ready  output  1  block accepts operands this cycle.
REQ-007 SHALL have port a  input  W  operand A, IEEE-754 layout {sign, exp, frac}.
REQ-008 SHALL have port b  input  W  operand B, same layout.
REQ-009 SHALL have port sub  input  1  1 = compute a-b, 0 = a+b.
REQ-010 SHALL have port out_valid  output  1  result present.
REQ-011 SHALL have port out_ready  input  1  consumer accepts result.
REQ-012 SHALL have port result  output  W  sum/difference.
REQ-013 SHALL have port flags  output  4  {invalid, overflow, underflow, inexact}.

Function
REQ-014 SHALL be a 3-stage pipeline: S1 unpack/special-detect/align, S2 signed magnitude add, S3 normalise/round/pack; latency exactly 3 cycles with out_ready held high.
REQ-015 SHALL transfer in on in_valid&in_ready and out on out_valid&out_ready; pipeline advance = !out_valid | out_ready; in_ready = advance.
REQ-016 SHALL hold result, flags, out_valid stable while out_valid&!out_ready; no operand lost, duplicated or reordered.
REQ-017 SHALL accept one operand pair per cycle (throughput 1) when not back-pressured; bubbles propagate as invalid stages.
REQ-018 SHALL apply sub by inverting b's sign before any other processing.
REQ-019 SHALL align with hidden bit, shifting the smaller-exponent significand right and retaining guard, round and sticky bits; shifts >= MAN_W+3 collapse to sticky only.
REQ-020 SHALL on unlike signs subtract smaller magnitude from larger; result sign = sign of larger magnitude.
REQ-021 SHALL normalise via leading-zero count (left shift) or carry (right shift one, exponent+1).
REQ-022 SHALL round to nearest, ties to even; rounding carry-out SHALL renormalise and increment exponent.
REQ-023 SHALL treat subnormal inputs as signed zero (flush-to-zero); results with biased exponent <= 0 SHALL become signed zero with underflow=1, inexact=1.
REQ-024 SHALL produce +inf/-inf with overflow=1, inexact=1 when rounded exponent >= 2^EXP_W-1.
REQ-025 SHALL output canonical quiet NaN {0, all-ones exp, 1 then zeros} for any NaN input or inf-inf of opposite effective signs; invalid=1 for inf-inf or signalling NaN input.
REQ-026 SHALL return inf unchanged (flags 0) when exactly one operand is inf.
REQ-027 SHALL return exact-cancellation zero as +0, except (-0)+(-0) = -0.
REQ-028 SHALL set inexact=1 whenever any of guard/round/sticky is nonzero after normalisation.
REQ-029 SHALL drive flags=0 for any exact, non-special result.

Reset
REQ-030 SHALL on rst_n low, immediately clear all stage valid bits; out_valid=0, result=0, flags=0.
REQ-031 SHALL discard in-flight operations when reset asserts mid-operation; no result emitted after release for pre-reset inputs.
REQ-032 SHALL drive in_ready=1 from first cycle after reset release.

Structure
REQ-033 SHALL place EXP_W/MAN_W defaults, bias function, qNaN constant and flag bit indices in shared package fp_pkg.
REQ-034 SHALL instantiate one sub-module fp_norm_round (leading-zero count, shift, RNE round, pack) in S3, reusable by the multiplier.
REQ-035 SHALL contain no combinational loops or unbounded loops; all shifts bounded by parameters.

Verification
REQ-036 SHALL test 0x3F800000 + 0x40000000, sub=0 -> 0x40400000, flags 0, 3 cycles later.
REQ-037 SHALL test 0x3F800000 + 0x33800000 -> 0x3F800000 inexact=1; 0x3F800001 + 0x33800000 -> 0x3F800002 inexact=1 (tie-to-even both ways).
REQ-038 SHALL test 0x7F7FFFFF + 0x7F7FFFFF -> 0x7F800000, overflow=1 inexact=1; 0x7F800000 - 0x7F800000 -> 0x7FC00000 invalid=1.
REQ-039 SHALL test 0x40490FDB - 0x40490FDB -> 0x00000000; 0x80000000 + 0x80000000 -> 0x80000000.
REQ-040 SHALL test back-pressure: 4 back-to-back inputs, out_ready low 5 cycles -> in_ready low, result stable, all 4 results delivered in order.
REQ-041 SHALL test rst_n pulse with 2 operations in flight -> out_valid=0 immediately, no stale result after release.

Source files
------------

// File: rtl/fp_pkg.sv
// Shared floating-point definitions for the adder pipeline and its norm/round stage.
// Holds format defaults, the exponent bias helper, the canonical quiet-NaN
// builder and the bit positions inside the 4-bit flags vector.
package fp_pkg;

  localparam int unsigned EXP_W_DEF = 8;
  localparam int unsigned MAN_W_DEF = 23;

  // flags = {invalid, overflow, underflow, inexact}
  localparam int unsigned FLAG_W        = 4;
  localparam int unsigned FLG_INVALID   = 3;
  localparam int unsigned FLG_OVERFLOW  = 2;
  localparam int unsigned FLG_UNDERFLOW = 1;
  localparam int unsigned FLG_INEXACT   = 0;

  // Exponent bias for a given exponent width.
  function automatic int unsigned fp_bias(input int unsigned exp_w);
    return (32'd1 << (exp_w - 1)) - 32'd1;
  endfunction

  // Canonical quiet NaN {0, all-ones exp, 1, zeros}, right-aligned in 64 bits.
  function automatic logic [63:0] fp_qnan(input int unsigned exp_w, input int unsigned man_w);
    logic [63:0] q;
    q = '0;
    for (int i = 0; i < 64; i++) begin
      if ((i >= int'(man_w) - 1) && (i < int'(man_w + exp_w))) q[i] = 1'b1;
    end
    return q;
  endfunction

endpackage

// File: rtl/fp_norm_round.sv
// Normalise, round-to-nearest-even and pack a significand/exponent pair.
// Purely combinational; intended as the last stage of an add or multiply pipe.
//   sign_i   : result sign
//   exp_i    : biased exponent (two's complement, EXP_W+2 bits) for the hidden-bit position
//   sig_i    : {carry, hidden, fraction[MAN_W], extra bits (>=3)}; zero means exact cancellation
//   result_c : packed IEEE-754 word
//   flags_c  : {invalid(always 0 here), overflow, underflow, inexact}
module fp_norm_round
  import fp_pkg::*;
#(
  parameter int unsigned EXP_W = EXP_W_DEF,
  parameter int unsigned MAN_W = MAN_W_DEF,
  parameter int unsigned IN_W  = MAN_W + 5
) (
  input  logic                   sign_i,
  input  logic [EXP_W+1:0]       exp_i,
  input  logic [IN_W-1:0]        sig_i,
  output logic [EXP_W+MAN_W:0]   result_c,
  output logic [FLAG_W-1:0]      flags_c
);

  localparam int unsigned NRM_W = IN_W - 1;
  localparam int unsigned EXTRA = NRM_W - (MAN_W + 1);
  localparam int unsigned LZ_W  = $clog2(NRM_W + 1);
  localparam int unsigned EXT_W = EXP_W + 2;
  localparam logic [EXT_W-2:0] EXP_OVF = (EXT_W-1)'((32'd1 << EXP_W) - 32'd1);

  logic [LZ_W-1:0]    lz;
  logic               found;
  logic [NRM_W-1:0]   norm;
  logic [EXT_W-1:0]   exp_n;
  logic [EXT_W-1:0]   exp_r;
  logic [MAN_W:0]     mant;
  logic [MAN_W+1:0]   mant_r;
  logic [MAN_W-1:0]   frac_r;
  logic               guard;
  logic               rest;
  logic               inexact;
  logic               rnd_up;

  // Leading-zero count below the carry position.
  always_comb begin
    lz    = '0;
    found = 1'b0;
    for (int i = NRM_W - 1; i >= 0; i--) begin
      if (!found) begin
        if (sig_i[i]) found = 1'b1;
        else          lz    = lz + LZ_W'(1);
      end
    end
  end

  // Normalise, round, then classify into zero / underflow / overflow / normal.
  always_comb begin
    norm     = '0;
    exp_n    = '0;
    result_c = '0;
    flags_c  = '0;
    if (sig_i[IN_W-1]) begin
      // carry out of the add: shift right one, fold the dropped bit into sticky
      norm  = {sig_i[IN_W-1:2], sig_i[1] | sig_i[0]};
      exp_n = exp_i + EXT_W'(1);
    end else begin
      norm  = sig_i[NRM_W-1:0] << lz;
      exp_n = exp_i - EXT_W'(lz);
    end

    mant    = norm[NRM_W-1 -: MAN_W+1];
    guard   = norm[EXTRA-1];
    rest    = |norm[EXTRA-2:0];
    inexact = guard | rest;
    rnd_up  = guard & (rest | mant[0]);
    mant_r  = {1'b0, mant} + (MAN_W+2)'(rnd_up);

    // rounding carry-out leaves 1.000..0: fraction is zero, exponent bumps
    exp_r  = mant_r[MAN_W+1] ? exp_n + EXT_W'(1) : exp_n;
    frac_r = mant_r[MAN_W+1] ? '0 : mant_r[MAN_W-1:0];

    if (sig_i == '0) begin
      result_c = '0;
    end else if (exp_r[EXT_W-1] || (exp_r == '0)) begin
      result_c                 = {sign_i, {(EXP_W+MAN_W){1'b0}}};
      flags_c[FLG_UNDERFLOW]   = 1'b1;
      flags_c[FLG_INEXACT]     = 1'b1;
    end else if (exp_r[EXT_W-2:0] >= EXP_OVF) begin
      result_c                 = {sign_i, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      flags_c[FLG_OVERFLOW]    = 1'b1;
      flags_c[FLG_INEXACT]     = 1'b1;
    end else begin
      result_c                 = {sign_i, exp_r[EXP_W-1:0], frac_r};
      flags_c[FLG_INEXACT]     = inexact;
    end
  end

endmodule

// File: rtl/fp_add_pipe.sv
// Three-stage IEEE-754 adder/subtractor with valid/ready handshakes.
//   S1 unpack, special-case detect, align; S2 signed-magnitude add;
//   S3 normalise/round/pack into the output register.
// Subnormal inputs are flushed to signed zero; rounding is RNE.
//   clk, rst_n          : clock, async active-low reset
//   in_valid/in_ready   : operand handshake (a, b, sub)
//   out_valid/out_ready : result handshake (result, flags)
module fp_add_pipe
  import fp_pkg::*;
#(
  parameter int unsigned EXP_W = EXP_W_DEF,
  parameter int unsigned MAN_W = MAN_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [EXP_W+MAN_W:0] a,
  input  logic [EXP_W+MAN_W:0] b,
  input  logic                 sub,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [EXP_W+MAN_W:0] result,
  output logic [FLAG_W-1:0]    flags
);

  localparam int unsigned W     = 1 + EXP_W + MAN_W;
  localparam int unsigned SIG_W = MAN_W + 1;
  localparam int unsigned ALN_W = MAN_W + 4;
  localparam int unsigned SUM_W = MAN_W + 5;
  localparam int unsigned EXT_W = EXP_W + 2;
  localparam logic [EXP_W-1:0] EXP_ALL1 = '1;
  localparam logic [W-1:0]     QNAN     = W'(fp_qnan(EXP_W, MAN_W));

  logic adv_c;

  // S1 combinational signals
  logic               a_s, b_s;
  logic [EXP_W-1:0]   a_e, b_e;
  logic [MAN_W-1:0]   a_f, b_f;
  logic               a_max, b_max, a_zero, b_zero;
  logic               a_nan, b_nan, a_inf, b_inf;
  logic               swap;
  logic [EXP_W-1:0]   big_e, sml_e, diff;
  logic [SIG_W-1:0]   a_sig, b_sig, sml_sig;
  logic [ALN_W-1:0]   sml_ext;

  logic               s1_spec_d;
  logic [W-1:0]       s1_spec_res_d;
  logic [FLAG_W-1:0]  s1_spec_flg_d;
  logic               s1_sign_d, s1_esub_d;
  logic [ALN_W-1:0]   s1_big_d, s1_sml_d;

  // Pipeline registers
  logic               s1_vld_q, s1_spec_q, s1_sign_q, s1_esub_q;
  logic [W-1:0]       s1_spec_res_q;
  logic [FLAG_W-1:0]  s1_spec_flg_q;
  logic [EXP_W-1:0]   s1_exp_q;
  logic [ALN_W-1:0]   s1_big_q, s1_sml_q;

  logic               s2_vld_q, s2_spec_q, s2_sign_q;
  logic [W-1:0]       s2_spec_res_q;
  logic [FLAG_W-1:0]  s2_spec_flg_q;
  logic [EXP_W-1:0]   s2_exp_q;
  logic [SUM_W-1:0]   s2_sum_d, s2_sum_q;

  logic [W-1:0]       nr_res_c;
  logic [FLAG_W-1:0]  nr_flg_c;

  // Single global stall: every stage moves when the output slot frees up.
  assign adv_c    = !out_valid | out_ready;
  assign in_ready = adv_c;

  // S1: unpack (sub flips b's sign first), classify, order by magnitude, align.
  always_comb begin
    a_s    = a[W-1];
    b_s    = b[W-1] ^ sub;
    a_e    = a[W-2 -: EXP_W];
    b_e    = b[W-2 -: EXP_W];
    a_f    = a[MAN_W-1:0];
    b_f    = b[MAN_W-1:0];
    a_max  = (a_e == EXP_ALL1);
    b_max  = (b_e == EXP_ALL1);
    a_zero = (a_e == '0);
    b_zero = (b_e == '0);
    a_nan  = a_max & (|a_f);
    b_nan  = b_max & (|b_f);
    a_inf  = a_max & ~(|a_f);
    b_inf  = b_max & ~(|b_f);

    // subnormals behave as zero: no hidden bit, no fraction
    a_sig  = a_zero ? '0 : {1'b1, a_f};
    b_sig  = b_zero ? '0 : {1'b1, b_f};
    swap   = {b_zero ? '0 : b_e, b_zero ? '0 : b_f} > {a_zero ? '0 : a_e, a_zero ? '0 : a_f};

    big_e     = swap ? b_e : a_e;
    sml_e     = swap ? (a_zero ? '0 : a_e) : (b_zero ? '0 : b_e);
    sml_sig   = swap ? a_sig : b_sig;
    diff      = big_e - sml_e;
    sml_ext   = {sml_sig, 3'b000};
    s1_sign_d = swap ? b_s : a_s;
    s1_esub_d = a_s ^ b_s;
    s1_big_d  = {swap ? b_sig : a_sig, 3'b000};

    // right-align the smaller operand, keeping everything shifted out as sticky
    if (32'(diff) >= MAN_W + 3) begin
      s1_sml_d = {{(ALN_W-1){1'b0}}, |sml_sig};
    end else begin
      s1_sml_d = (sml_ext >> diff) |
                 ALN_W'(|(sml_ext & ~({ALN_W{1'b1}} << diff)));
    end

    // NaN / infinity / double-zero results bypass the arithmetic path
    s1_spec_d     = a_max | b_max | (a_zero & b_zero);
    s1_spec_res_d = '0;
    s1_spec_flg_d = '0;
    if (a_nan || b_nan || (a_inf && b_inf && (a_s != b_s))) begin
      s1_spec_res_d              = QNAN;
      s1_spec_flg_d[FLG_INVALID] = (a_nan & ~a_f[MAN_W-1]) | (b_nan & ~b_f[MAN_W-1]) |
                                   (a_inf & b_inf);
    end else if (a_inf) begin
      s1_spec_res_d = {a_s, a[W-2:0]};
    end else if (b_inf) begin
      s1_spec_res_d = {b_s, b[W-2:0]};
    end else begin
      // only -0 + -0 keeps the negative sign
      s1_spec_res_d = {a_s & b_s, {(W-1){1'b0}}};
    end
  end

  // S2: magnitude add or subtract; larger magnitude is always the minuend.
  always_comb begin
    if (s1_esub_q) s2_sum_d = {1'b0, s1_big_q} - {1'b0, s1_sml_q};
    else           s2_sum_d = {1'b0, s1_big_q} + {1'b0, s1_sml_q};
  end

  // S3: normalise, round and pack.
  fp_norm_round #(
    .EXP_W (EXP_W),
    .MAN_W (MAN_W),
    .IN_W  (SUM_W)
  ) u_norm_round (
    .sign_i   (s2_sign_q),
    .exp_i    (EXT_W'(s2_exp_q)),
    .sig_i    (s2_sum_q),
    .result_c (nr_res_c),
    .flags_c  (nr_flg_c)
  );

  // Pipeline registers; everything advances together or holds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld_q      <= 1'b0;
      s1_spec_q     <= 1'b0;
      s1_spec_res_q <= '0;
      s1_spec_flg_q <= '0;
      s1_sign_q     <= 1'b0;
      s1_esub_q     <= 1'b0;
      s1_exp_q      <= '0;
      s1_big_q      <= '0;
      s1_sml_q      <= '0;
      s2_vld_q      <= 1'b0;
      s2_spec_q     <= 1'b0;
      s2_spec_res_q <= '0;
      s2_spec_flg_q <= '0;
      s2_sign_q     <= 1'b0;
      s2_exp_q      <= '0;
      s2_sum_q      <= '0;
      out_valid     <= 1'b0;
      result        <= '0;
      flags         <= '0;
    end else if (adv_c) begin
      s1_vld_q      <= in_valid;
      s1_spec_q     <= s1_spec_d;
      s1_spec_res_q <= s1_spec_res_d;
      s1_spec_flg_q <= s1_spec_flg_d;
      s1_sign_q     <= s1_sign_d;
      s1_esub_q     <= s1_esub_d;
      s1_exp_q      <= big_e;
      s1_big_q      <= s1_big_d;
      s1_sml_q      <= s1_sml_d;
      s2_vld_q      <= s1_vld_q;
      s2_spec_q     <= s1_spec_q;
      s2_spec_res_q <= s1_spec_res_q;
      s2_spec_flg_q <= s1_spec_flg_q;
      s2_sign_q     <= s1_sign_q;
      s2_exp_q      <= s1_exp_q;
      s2_sum_q      <= s2_sum_d;
      out_valid     <= s2_vld_q;
      result        <= s2_spec_q ? s2_spec_res_q : nr_res_c;
      flags         <= s2_spec_q ? s2_spec_flg_q : nr_flg_c;
    end
  end

endmodule

// File: tb/tb_fp_add_pipe.sv
// Directed scoreboard bench for fp_add_pipe (single precision defaults).
module tb_fp_add_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a, b;
  logic        sub;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic [3:0]  flags;

  typedef struct packed {
    logic [31:0] res;
    logic [3:0]  flg;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   passed = 0;

  fp_add_pipe dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .flags     (flags)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, expv);
  endtask

  // Output monitor: pops the scoreboard on each transfer and checks held outputs under stall.
  logic        hold_prev = 1'b0;
  logic [35:0] prev_out  = '0;
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (hold_prev)
        check("stall_hold", 64'({out_valid, result, flags}), 64'({1'b1, prev_out}));
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_out", 64'(out_valid), 64'(0));
        end else begin
          e = sb.pop_front();
          check("result", 64'({result, flags}), 64'({e.res, e.flg}));
        end
      end
      hold_prev = out_valid && !out_ready;
      prev_out  = {result, flags};
    end else begin
      hold_prev = 1'b0;
    end
  end

  // Present one operand pair; record its expectation when accepted.
  task automatic send(input logic [31:0] ta, input logic [31:0] tb_v, input logic tsub,
                      input logic [31:0] er, input logic [3:0] ef);
    int   waits;
    exp_t e;
    waits    = 0;
    a        = ta;
    b        = tb_v;
    sub      = tsub;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && waits < 50) begin
      waits++;
      @(negedge clk);
    end
    if (!in_ready) begin
      check("accept_timeout", 64'(in_ready), 64'(1));
    end else begin
      e.res = er;
      e.flg = ef;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    #1;
    check("drain", 64'(sb.size()), 64'(0));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int   lat;
    logic stale;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    sub       = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", 64'({out_valid, result, flags}), 64'(0));
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("in_ready_after_reset", 64'(in_ready), 64'(1));

    // 1.0 + 2.0 with latency measurement
    send(32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 4'b0000);
    in_valid = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!out_valid && lat < 10);
    check("latency", 64'(lat), 64'(3));
    drain();

    // Directed vectors, issued back to back: {invalid, overflow, underflow, inexact}
    send(32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 4'b0001);
    send(32'h3F800001, 32'h33800000, 1'b0, 32'h3F800002, 4'b0001);
    send(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 4'b0101);
    send(32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 4'b1000);
    send(32'h40490FDB, 32'h40490FDB, 1'b1, 32'h00000000, 4'b0000);
    send(32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 4'b0000);
    send(32'h3FC00000, 32'h3F800000, 1'b1, 32'h3F000000, 4'b0000);
    send(32'hBF800000, 32'h3F000000, 1'b0, 32'hBF000000, 4'b0000);
    send(32'h3FC00000, 32'h3FC00000, 1'b0, 32'h40400000, 4'b0000);
    send(32'hFF800000, 32'h3F800000, 1'b0, 32'hFF800000, 4'b0000);
    send(32'hFF800000, 32'hFF800000, 1'b1, 32'h7FC00000, 4'b1000);
    send(32'h7FA00000, 32'h3F800000, 1'b0, 32'h7FC00000, 4'b1000);
    send(32'h7FC00001, 32'h3F800000, 1'b0, 32'h7FC00000, 4'b0000);
    send(32'h00000001, 32'h3F800000, 1'b0, 32'h3F800000, 4'b0000);
    send(32'h00800001, 32'h00800000, 1'b1, 32'h00000000, 4'b0011);
    send(32'h3F800000, 32'h32000000, 1'b0, 32'h3F800000, 4'b0001);
    send(32'h3F800000, 32'h30800000, 1'b1, 32'h3F800000, 4'b0001);
    send(32'h3F800000, 32'hBF800000, 1'b0, 32'h00000000, 4'b0000);
    send(32'h00000000, 32'h80000000, 1'b0, 32'h00000000, 4'b0000);
    send(32'h3FFFFFFF, 32'h33800000, 1'b0, 32'h40000000, 4'b0001);
    in_valid = 1'b0;
    drain();

    // Back-pressure: four back-to-back inputs then out_ready low for 5 cycles
    send(32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 4'b0000);
    send(32'h40000000, 32'h40000000, 1'b0, 32'h40800000, 4'b0000);
    send(32'h3F800000, 32'h3F000000, 1'b0, 32'h3FC00000, 4'b0000);
    send(32'h40800000, 32'h40800000, 1'b0, 32'h41000000, 4'b0000);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_in_ready_low", 64'({in_ready, out_valid}), 64'(2'b01));
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    drain();

    // Reset with operations in flight: one held at the output, two inside
    out_ready = 1'b0;
    send(32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 4'b0000);
    send(32'h40000000, 32'h40000000, 1'b0, 32'h40800000, 4'b0000);
    send(32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 4'b0000);
    in_valid = 1'b0;
    check("pre_reset_out_valid", 64'(out_valid), 64'(1));
    rst_n = 1'b0;
    #1;
    check("reset_async", 64'({out_valid, result, flags}), 64'(0));
    sb.delete();
    out_ready = 1'b1;
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("in_ready_after_pulse", 64'(in_ready), 64'(1));
    stale = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      stale = stale | out_valid;
    end
    check("no_stale_result", 64'(stale), 64'(0));

    // Pipeline still works after the pulse
    @(posedge clk);
    #1;
    send(32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 4'b0000);
    in_valid = 1'b0;
    drain();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
